// File: rtl/regfile_dump_serializer.sv
// rtl/regfile_dump_serializer.sv - walks the register file through one read port and streams a header/data/checksum byte frame
module regfile_dump_serializer #(
    parameter int         WORD_SIZE   = 16,
    parameter int         NUM_REGS    = 4,
    parameter int         ADDR_W      = 2,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dump_req,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    rf_read_addr,
    input  logic [WORD_SIZE-1:0] rf_read_data,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_LOAD,
        S_SEND_HI,
        S_SEND_LO,
        S_CHECKSUM,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t               state, state_nxt;
    logic [ADDR_W-1:0]    idx, idx_nxt;
    logic [WORD_SIZE-1:0] word_q, word_nxt;
    logic [7:0]           csum_q, csum_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            word_q <= '0;
            csum_q <= '0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            word_q <= word_nxt;
            csum_q <= csum_nxt;
        end
    end

    // Outputs depend only on registered state, so nothing from the inputs reaches them combinationally.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        word_nxt     = word_q;
        csum_nxt     = csum_q;
        busy         = (state != S_IDLE);
        done         = 1'b0;
        out_valid    = 1'b0;
        out_data     = 8'h00;
        rf_read_addr = '0;
        case (state)
            S_IDLE: begin
                if (dump_req) begin
                    state_nxt = S_HEADER;
                    idx_nxt   = '0;
                    csum_nxt  = '0;
                end
            end
            S_HEADER: begin
                out_valid = 1'b1;
                out_data  = HEADER_BYTE;
                if (out_ready) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                rf_read_addr = idx;
                word_nxt     = rf_read_data;
                state_nxt    = S_SEND_HI;
            end
            S_SEND_HI: begin
                out_valid = 1'b1;
                out_data  = word_q[15:8];
                if (out_ready) begin
                    csum_nxt  = csum_q ^ word_q[15:8];
                    state_nxt = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                out_valid = 1'b1;
                out_data  = word_q[7:0];
                if (out_ready) begin
                    csum_nxt = csum_q ^ word_q[7:0];
                    if (idx == LAST_IDX) begin
                        state_nxt = S_CHECKSUM;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_CHECKSUM: begin
                out_valid = 1'b1;
                out_data  = csum_q;
                if (out_ready) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_serializer.sv
// tb/tb_regfile_dump_serializer.sv - directed self-checking bench for regfile_dump_serializer
`timescale 1ns/1ps
module tb_regfile_dump_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        dump_req;
    logic        busy;
    logic        done;
    logic [1:0]  rf_read_addr;
    logic [15:0] rf_read_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    logic [15:0] regs [4];
    assign rf_read_data = regs[rf_read_addr];

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] got [$];
    int busy_cycles, done_pulses, stall_err, gap_cycles;
    bit timed_out;

    logic [7:0] exp_basic [10] = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h40};
    logic [7:0] exp_write [10] = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h55, 8'h55, 8'h40};

    regfile_dump_serializer dut (
        .clk          (clk),
        .reset        (reset),
        .dump_req     (dump_req),
        .busy         (busy),
        .done         (done),
        .rf_read_addr (rf_read_addr),
        .rf_read_data (rf_read_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    task automatic load_regs();
        regs[0] = 16'h1234;
        regs[1] = 16'hABCD;
        regs[2] = 16'h0000;
        regs[3] = 16'hFFFF;
    endtask

    // Runs one frame at negedges. mode 0: ready high; mode 1: ready 1,0,0,1 repeating.
    // hook 0: drop req; 1: drop req + write R3/R0 in SEND_HI of R0; 2: req at bytes 3 and 7;
    // hook 3: keep req high; 4: drop req once the frame has started.
    task automatic capture(input int mode, input int hook, input int budget);
        logic [7:0] held;
        bit stalled;
        int cyc;
        held = 8'h00;
        stalled = 1'b0;
        cyc = 0;
        got.delete();
        busy_cycles = 0;
        done_pulses = 0;
        stall_err   = 0;
        gap_cycles  = 0;
        timed_out   = 1'b1;
        while (cyc < budget) begin
            @(negedge clk);
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            case (hook)
                0: dump_req = 1'b0;
                1: begin
                    dump_req = 1'b0;
                    if (got.size() == 1 && out_valid) begin
                        regs[3] = 16'h5555;
                        regs[0] = 16'h9999;
                    end
                end
                2: dump_req = (got.size() == 3 || got.size() == 7);
                4: if (got.size() >= 1) dump_req = 1'b0;
                default: ;
            endcase
            if (stalled && (!out_valid || out_data !== held)) stall_err++;
            if (busy) busy_cycles++;
            if (done) done_pulses++;
            if (busy && !out_valid && !done) gap_cycles++;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                held = out_data;
            end
            cyc++;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        dump_req = 1'b1;
        out_ready = 1'b1;
        load_regs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if ({busy, done, out_valid, out_data, rf_read_addr} !== 13'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle %0d: busy=%b done=%b valid=%b data=%h addr=%h, required all 0",
                         i, busy, done, out_valid, out_data, rf_read_addr);
            end
        end
        dump_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: busy=%b valid=%b, required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_basic_frame();
        load_regs();
        @(negedge clk);
        dump_req = 1'b1;
        capture(0, 0, 200);
        tests_run++;
        if (timed_out || got.size() != 10) begin
            tests_failed++;
            $display("FAIL basic_len: timeout=%0d bytes=%0d, required 0 10", timed_out, got.size());
        end
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (i >= got.size() || got[i] !== exp_basic[i]) begin
                tests_failed++;
                $display("FAIL basic_byte%0d: got %h, required %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_basic[i]);
            end
        end
        tests_run++;
        if (busy_cycles != 15 || done_pulses != 1 || gap_cycles != 4) begin
            tests_failed++;
            $display("FAIL basic_timing: busy=%0d done=%0d gaps=%0d, required 15 1 4", busy_cycles, done_pulses, gap_cycles);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_after_done: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_backpressure();
        load_regs();
        @(negedge clk);
        dump_req = 1'b1;
        capture(1, 0, 300);
        tests_run++;
        if (timed_out || got.size() != 10 || stall_err != 0 || done_pulses != 1) begin
            tests_failed++;
            $display("FAIL bp_frame: timeout=%0d bytes=%0d stall_err=%0d done=%0d, required 0 10 0 1",
                     timed_out, got.size(), stall_err, done_pulses);
        end
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (i >= got.size() || got[i] !== exp_basic[i]) begin
                tests_failed++;
                $display("FAIL bp_byte%0d: got %h, required %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_basic[i]);
            end
        end
    endtask

    task automatic test_non_atomic();
        load_regs();
        @(negedge clk);
        dump_req = 1'b1;
        capture(0, 1, 200);
        tests_run++;
        if (timed_out || got.size() != 10) begin
            tests_failed++;
            $display("FAIL na_len: timeout=%0d bytes=%0d, required 0 10", timed_out, got.size());
        end
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (i >= got.size() || got[i] !== exp_write[i]) begin
                tests_failed++;
                $display("FAIL na_byte%0d: got %h, required %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_write[i]);
            end
        end
        load_regs();
    endtask

    task automatic test_req_during_busy();
        int extra;
        load_regs();
        @(negedge clk);
        dump_req = 1'b1;
        capture(0, 2, 200);
        dump_req = 1'b0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || done || out_valid) extra++;
        end
        tests_run++;
        if (timed_out || got.size() != 10 || done_pulses != 1 || extra != 0) begin
            tests_failed++;
            $display("FAIL busy_req_ignored: timeout=%0d bytes=%0d done=%0d extra_active=%0d, required 0 10 1 0",
                     timed_out, got.size(), done_pulses, extra);
        end
    endtask

    task automatic test_back_to_back();
        load_regs();
        @(negedge clk);
        dump_req = 1'b1;
        capture(0, 3, 200);
        tests_run++;
        if (timed_out || got.size() != 10 || got[0] !== 8'hA5 || got[9] !== 8'h40) begin
            tests_failed++;
            $display("FAIL b2b_first: timeout=%0d bytes=%0d first=%h last=%h, required 0 10 a5 40",
                     timed_out, got.size(), (got.size() > 0) ? got[0] : 8'hxx, (got.size() > 9) ? got[9] : 8'hxx);
        end
        capture(0, 4, 200);
        tests_run++;
        if (timed_out || got.size() != 10 || got[0] !== 8'hA5 || got[9] !== 8'h40 || busy_cycles != 15) begin
            tests_failed++;
            $display("FAIL b2b_second: timeout=%0d bytes=%0d first=%h last=%h busy=%0d, required 0 10 a5 40 15",
                     timed_out, got.size(), (got.size() > 0) ? got[0] : 8'hxx, (got.size() > 9) ? got[9] : 8'hxx, busy_cycles);
        end
        dump_req = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_async_reset();
        bit found;
        int leaks;
        load_regs();
        found = 1'b0;
        @(negedge clk);
        dump_req = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            dump_req = 1'b0;
            if (out_valid && out_data === 8'hCD) begin
                found = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL ar_reach_r1lo: R1 low byte never offered");
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, out_valid, out_data, rf_read_addr} !== 13'd0) begin
            tests_failed++;
            $display("FAIL ar_immediate: busy=%b done=%b valid=%b data=%h addr=%h, required all 0",
                     busy, done, out_valid, out_data, rf_read_addr);
        end
        leaks = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid || busy) leaks++;
        end
        reset = 1'b1;
        @(negedge clk);
        if (out_valid || busy) leaks++;
        tests_run++;
        if (leaks != 0) begin
            tests_failed++;
            $display("FAIL ar_held_idle: active cycles=%0d, required 0", leaks);
        end
        dump_req = 1'b1;
        capture(0, 0, 200);
        tests_run++;
        if (timed_out || got.size() != 10 || busy_cycles != 15) begin
            tests_failed++;
            $display("FAIL ar_restart_len: timeout=%0d bytes=%0d busy=%0d, required 0 10 15", timed_out, got.size(), busy_cycles);
        end
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (i >= got.size() || got[i] !== exp_basic[i]) begin
                tests_failed++;
                $display("FAIL ar_byte%0d: got %h, required %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_basic[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_non_atomic();
        test_req_during_busy();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
